mem_stage_master: RTL
=====================

# mem_stage_master

Initiator side of the MEM-stage data-memory interface. Accepts a load or store from the EXE/MEM pipeline register and runs it as four handshaked byte beats on a byte-wide memory port. Assembles load words little-endian and freezes the pipeline until the access completes. Sits between the EXE/MEM register and the data memory; its outputs feed the MEM/WB register and the hazard/freeze logic.

## Interface
- WORD_WIDTH, 32, pipeline word width; fixed at 32, since four byte beats form one word
- ADDR_BASE, 1024, byte offset subtracted from the ALU address to form the memory address
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_res  in  WORD_WIDTH  effective byte address from EXE
- val_rm  in  WORD_WIDTH  store data
- mem_r_en  in  1  load request, level, held by pipeline while frozen
- mem_w_en  in  1  store request, level, held by pipeline while frozen
- freeze  out  1  stall request to the pipeline registers
- res_data  out  WORD_WIDTH  last completed load word
- res_valid  out  1  one-cycle pulse when res_data is updated by a load
- bus_req  out  1  beat request to memory
- bus_we  out  1  1 = write beat, 0 = read beat
- bus_addr  out  WORD_WIDTH  byte address of the current beat
- bus_wdata  out  8  write byte of the current beat
- bus_ack  in  1  memory accepts the beat; read byte is valid in the same cycle
- bus_rdata  in  8  read byte, sampled when bus_req && bus_ack

## Operation
- States: IDLE, XFER, DONE.
- IDLE, no request: freeze = 0, bus_req = 0.
- IDLE, mem_r_en or mem_w_en asserted:
  - freeze = 1, combinationally, in the same cycle.
  - At the clock edge: base = {alu_res[W-1:2], 2'b00} - ADDR_BASE, taken modulo 2^W so results below zero wrap. Store val_rm. Store op = write if mem_w_en, else read; mem_w_en wins when both are set. beat = 0. Go to XFER.
- XFER:
  - bus_req = 1, bus_we = op, bus_addr = {base[W-1:2], beat[1:0]}. The low-bit substitution never carries into base[W-1:2].
  - bus_wdata = val_rm[8*beat+7 : 8*beat]. Driven for reads as well; memory ignores it.
  - bus_addr, bus_we and bus_wdata stay stable while bus_ack = 0.
  - On bus_req && bus_ack:
    - Read: bus_rdata is stored in byte lane beat.
    - beat < 3: beat increments.
    - beat == 3: go to DONE.
  - freeze = 1 throughout XFER.
- DONE, one cycle:
  - freeze = 0 and bus_req = 0; the pipeline advances at this edge.
  - Read: res_data takes the assembled word and res_valid = 1.
  - Write: res_data keeps its value and res_valid = 0.
  - The mem_r_en/mem_w_en still present in this cycle belong to the finished access. They are ignored. Always go to IDLE.
- res_data holds its value until the next completed load.

## Timing
- Reset values: state IDLE, freeze 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, res_data 0, res_valid 0, beat 0.
- rst clears all state asynchronously. A reset during XFER drops bus_req immediately and abandons partial read data.
- Latency with bus_ack tied to 1:
  - Request first seen in cycle 0 (IDLE, freeze 1).
  - Beats 0–3 in cycles 1–4.
  - DONE in cycle 5: res_valid 1, freeze 0.
  - freeze is high for exactly 5 cycles; the next request can be accepted in cycle 6.
- Each cycle with bus_ack = 0 during XFER adds one cycle of freeze.
- Only one access is ever outstanding. bus_req is never asserted in IDLE or DONE.

## Test plan
- Load, ack tied 1, alu_res = 0x0000_0404, memory bytes at 4..7 = 0x11,0x22,0x33,0x44:
  - bus_addr sequence is 4,5,6,7.
  - res_data = 0x4433_2211 with res_valid in cycle 5.
  - freeze high for cycles 0–4.
- Store, alu_res = 0x0000_0407, val_rm = 0xDEAD_BEEF:
  - bus_addr sequence is 4,5,6,7, because the low address bits are ignored.
  - bus_wdata sequence is 0xEF,0xBE,0xAD,0xDE with bus_we = 1.
  - res_data is unchanged and res_valid stays 0.
- Load with bus_ack low for 3 cycles on beat 2:
  - bus_addr and bus_req hold steady during the wait.
  - freeze lasts 8 cycles and the assembled word is correct.
- mem_r_en and mem_w_en both high:
  - A write is performed and res_valid stays 0.
  - Back-to-back requests: the second request is accepted in the cycle after DONE; there is no duplicate access in DONE.
- alu_res = 0x0000_0000:
  - base wraps to 0xFFFF_FC00.
  - bus_addr sequence is 0xFFFF_FC00..0xFFFF_FC03.
- rst asserted mid-XFER after beat 1:
  - All outputs return to reset values at once.
  - The next load completes correctly, with no leftover bytes from the aborted access.

Source files
------------

// File: rtl/mem_stage_master.sv
// mem_stage_master
// Initiator side of the MEM-stage data-memory interface. A load or store from
// the EXE/MEM register is executed as four handshaked byte beats on a
// byte-wide memory port. Load bytes are assembled little-endian, and the
// pipeline is frozen until the access completes.
module mem_stage_master #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_BASE  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] alu_res,
  input  logic [WORD_WIDTH-1:0] val_rm,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  output logic                  freeze,
  output logic [WORD_WIDTH-1:0] res_data,
  output logic                  res_valid,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [WORD_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_nx;

  logic [WORD_WIDTH-1:0] base_q;
  logic [WORD_WIDTH-1:0] base_nx;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rbuf_q;
  logic [WORD_WIDTH-1:0] rbuf_nx;
  logic [WORD_WIDTH-1:0] res_q;
  logic                  res_valid_q;
  logic                  op_we_q;
  logic [1:0]            beat_q;

  logic                  req_in;
  logic                  beat_fire;
  logic                  last_beat;

  assign req_in    = mem_r_en | mem_w_en;
  assign beat_fire = (state_q == XFER) && bus_ack;
  assign last_beat = beat_fire && (beat_q == 2'd3);

  // Word-aligned base, rebased by ADDR_BASE; subtraction wraps modulo 2^W.
  assign base_nx = (alu_res & ~WORD_WIDTH'(3)) - WORD_WIDTH'(ADDR_BASE);

  // Merge the incoming read byte into its little-endian lane.
  always_comb begin
    rbuf_nx = rbuf_q;
    if (beat_fire && !op_we_q) begin
      rbuf_nx[{beat_q, 3'b000} +: 8] = bus_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic; requests seen in DONE belong to the finished access.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (req_in) state_nx = XFER;
      XFER: if (last_beat) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus and stall outputs; the beat address/data are only driven in XFER.
  always_comb begin
    freeze    = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE: freeze = req_in;
      XFER: begin
        freeze    = 1'b1;
        bus_req   = 1'b1;
        bus_we    = op_we_q;
        // Low two bits are replaced by the beat index, never carried upward.
        bus_addr  = (base_q & ~WORD_WIDTH'(3)) | WORD_WIDTH'(beat_q);
        bus_wdata = wdata_q[{beat_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Access capture, beat sequencing and load-word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      op_we_q     <= 1'b0;
      beat_q      <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_in) begin
            base_q  <= base_nx;
            wdata_q <= val_rm;
            op_we_q <= mem_w_en;
            beat_q  <= '0;
            rbuf_q  <= '0;
          end
        end
        XFER: begin
          if (beat_fire) begin
            rbuf_q <= rbuf_nx;
            if (beat_q != 2'd3) begin
              beat_q <= beat_q + 2'd1;
            end else if (!op_we_q) begin
              // Publish the word at the edge entering DONE so it is visible
              // together with res_valid during the DONE cycle.
              res_q       <= rbuf_nx;
              res_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data  = res_q;
  assign res_valid = res_valid_q;

endmodule
